// File: rtl/switch_reader.sv
// switch_reader: memory-mapped reader for 16 slide switches and 5 push-buttons.
// Pins are two-stage synchronized, debounced per input, and button presses are
// captured as sticky events that clear when word 2 is read.
// Optional feature: define SWITCH_IRQ_EN to add the registered IRQ output.
module switch_reader #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [15:0] SW,
  input  logic [4:0]  BTN,
  input  logic        RE,
  input  logic [1:0]  A,
`ifdef SWITCH_IRQ_EN
  output logic        IRQ,
`endif
  output logic [31:0] RD
);

  localparam int unsigned NSW  = 16;
  localparam int unsigned NBTN = 5;
  localparam int unsigned NPIN = NSW + NBTN;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NPIN-1:0]  pins;
  logic [NPIN-1:0]  s1;
  logic [NPIN-1:0]  s2;
  logic [NPIN-1:0]  db;
  logic [CNT_W-1:0] cnt [NPIN];

  logic [NSW-1:0]   sw_db;
  logic [NBTN-1:0]  btn_db;
  logic [NBTN-1:0]  btn_prev;
  logic [NBTN-1:0]  btn_event;
  logic [NBTN-1:0]  rise;
  logic             clr;

  // Buttons occupy the top bits so one loop handles all 21 inputs.
  assign pins   = {BTN, SW};
  assign sw_db  = db[NSW-1:0];
  assign btn_db = db[NPIN-1:NSW];
  assign rise   = btn_db & ~btn_prev;
  assign clr    = RE && (A == 2'd2);

  // Two-flop synchronizer and per-input debounce counters.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      s1 <= '0;
      s2 <= '0;
      db <= '0;
      for (int i = 0; i < NPIN; i++) cnt[i] <= '0;
    end else begin
      s1 <= pins;
      s2 <= s1;
      for (int i = 0; i < NPIN; i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          db[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Rising-edge capture into sticky events; a read of word 2 clears all but a same-edge rise.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      btn_prev  <= '0;
      btn_event <= '0;
    end else begin
      btn_prev <= btn_db;
      if (clr) btn_event <= rise;
      else     btn_event <= btn_event | rise;
    end
  end

`ifdef SWITCH_IRQ_EN
  // Interrupt follows any pending event one cycle later.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) IRQ <= 1'b0;
    else       IRQ <= |btn_event;
  end
`endif

  // Read-only register window, combinational on A.
  always_comb begin
    RD = '0;
    case (A)
      2'd0:    RD = {16'b0, sw_db};
      2'd1:    RD = {27'b0, btn_db};
      2'd2:    RD = {27'b0, btn_event};
      default: RD = '0;
    endcase
  end

endmodule

// File: tb/tb_switch_reader.sv
// Testbench for switch_reader with DEBOUNCE_CYCLES=4: directed scenarios plus
// randomized pin/read traffic, all checked against a window-based reference model.
module tb_switch_reader;

  localparam int unsigned DC = 4;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [15:0] SW;
  logic [4:0]  BTN;
  logic        RE;
  logic [1:0]  A;
  logic [31:0] RD;
`ifdef SWITCH_IRQ_EN
  logic        IRQ;
`endif

  int checks = 0;
  int errors = 0;

  switch_reader #(.DEBOUNCE_CYCLES(DC), .CNT_W(20)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .SW    (SW),
    .BTN   (BTN),
    .RE    (RE),
    .A     (A),
`ifdef SWITCH_IRQ_EN
    .IRQ   (IRQ),
`endif
    .RD    (RD)
  );

  always #5 CLK = ~CLK;

  // Reference model: a pin's debounced value takes a new value once the last
  // DC synchronized samples all agree on it; synchronized = pin two edges ago.
  logic [20:0] win [DC];
  logic [20:0] pd1, pd2;
  logic [20:0] m_db;
  logic [4:0]  m_prev, m_evt;
  logic        m_irq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DC; i++) win[i] = '0;
    pd1 = '0; pd2 = '0; m_db = '0; m_prev = '0; m_evt = '0; m_irq = 1'b0;
  endtask

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {16'b0, m_db[15:0]};
      2'd1:    return {27'b0, m_db[20:16]};
      2'd2:    return {27'b0, m_evt};
      default: return 32'b0;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    logic [20:0] s2v, new_db;
    logic [4:0]  rise;
    logic        same;
    if (Reset) begin
      model_clear();
      return;
    end
    s2v = pd2;
    for (int i = DC - 1; i > 0; i--) win[i] = win[i-1];
    win[0] = s2v;
    new_db = m_db;
    for (int b = 0; b < 21; b++) begin
      same = 1'b1;
      for (int i = 0; i < DC; i++) if (win[i][b] != s2v[b]) same = 1'b0;
      if (same && s2v[b] != m_db[b]) new_db[b] = s2v[b];
    end
    rise   = m_db[20:16] & ~m_prev;
    m_irq  = |m_evt;
    m_evt  = (RE && A == 2'd2) ? rise : (m_evt | rise);
    m_prev = m_db[20:16];
    m_db   = new_db;
    pd2    = pd1;
    pd1    = {BTN, SW};
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic cycle();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    check("rd_model", RD, model_rd(A));
`ifdef SWITCH_IRQ_EN
    check("irq_model", {31'b0, IRQ}, {31'b0, m_irq});
`endif
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clear_events();
    RE = 1'b1; A = 2'd2;
    cycle();
    RE = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; SW = '0; BTN = '0; RE = 1'b0; A = 2'd0;
    model_clear();
    #1;
    check("reset_rd0", RD, 32'h0);
`ifdef SWITCH_IRQ_EN
    check("reset_irq", {31'b0, IRQ}, 32'h0);
`endif
    @(negedge CLK); @(negedge CLK);

    // Switch latency: stable before posedge 1, visible from posedge 6.
    SW = 16'hA5C3;
    @(negedge CLK);
    Reset = 1'b0;
    cycles(5);
    check("sw_lat_p5", RD, 32'h0);
    cycle();
    check("sw_lat_p6", RD, 32'h0000A5C3);

    // Short glitch on SW[0] never reaches the debounced value.
    SW = 16'h0000;
    cycles(8);
    check("sw_zero", RD, 32'h0);
    SW = 16'h0001;
    cycles(3);
    SW = 16'h0000;
    cycles(10);
    check("sw_glitch", RD, 32'h0);

    // BTN[2] press, event, read-to-clear, release sets no event.
    BTN = 5'b00100; A = 2'd1;
    cycles(5);
    check("btn2_p5", RD, 32'h0);
    cycle();
    check("btn2_p6", RD, 32'h4);
    A = 2'd2;
    cycle();
    check("btn2_evt", RD, 32'h4);
    clear_events();
    check("btn2_clr", RD, 32'h0);
    cycles(2);
    BTN = 5'b00000;
    cycles(8);
    check("btn2_release", RD, 32'h0);

    // A new BTN[1] rise on the same edge as a clearing read is retained.
    BTN = 5'b00001;
    cycles(7);
    check("btn0_evt", RD, 32'h1);
    BTN = 5'b00011;
    cycles(6);
    check("btn1_pre", RD, 32'h1);
    RE = 1'b1;
    cycle();
    RE = 1'b0;
    check("clr_keep_rise", RD, 32'h2);

    // Reset mid-debounce of held BTN[4]; it requalifies and raises a fresh event.
    BTN = 5'b00000;
    cycles(8);
    clear_events();
    BTN = 5'b10000; A = 2'd1;
    cycles(4);
    Reset = 1'b1;
    model_clear();
    for (int a = 0; a < 4; a++) begin
      A = 2'(a);
      #1;
      check("rst_rd", RD, 32'h0);
    end
    A = 2'd1;
    cycles(2);
    Reset = 1'b0;
    cycles(5);
    check("btn4_p5", RD, 32'h0);
    cycle();
    check("btn4_p6", RD, 32'h10);
    A = 2'd2;
    cycle();
    check("btn4_evt", RD, 32'h10);

    // BTN[3] event and the interrupt timing around it.
    BTN = 5'b00000;
    cycles(8);
    clear_events();
    BTN = 5'b01000;
    cycles(7);
    check("btn3_evt", RD, 32'h8);
`ifdef SWITCH_IRQ_EN
    check("irq_lag", {31'b0, IRQ}, 32'h0);
    cycle();
    check("irq_set", {31'b0, IRQ}, 32'h1);
    clear_events();
    check("irq_hold", {31'b0, IRQ}, 32'h1);
    cycle();
    check("irq_clr", {31'b0, IRQ}, 32'h0);
`else
    cycle();
    clear_events();
    check("btn3_clr", RD, 32'h0);
`endif

    // Randomized pins, reads and occasional resets.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 5) == 0) SW = SW ^ (16'h1 << $urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) BTN = 5'($urandom);
      RE = ($urandom_range(0, 3) == 0);
      A  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) begin
        Reset = 1'b1;
        model_clear();
        #1;
        check("rnd_rst", RD, 32'h0);
        cycle();
        Reset = 1'b0;
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
